// File: rtl/ysyx_22050039_lsu.sv
// Load/store unit: one memory op in flight between execute and writeback.
// Aligns store data/masks onto an 8-byte memory port and extends returned load data.
module ysyx_22050039_lsu #(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wen,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [RD_W-1:0] req_rd,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic            mem_wen,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_wmask,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic [RD_W-1:0] resp_rd,
  output logic            resp_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_RESP} state_e;

  state_e          state_q;
  logic            wen_q, uns_q, err_q;
  logic [1:0]      size_q;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
  logic [RD_W-1:0] rd_q;

  logic            misaligned;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_data_d;
  logic [7:0]      size_mask;

  always_comb begin
    unique case (req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      default: misaligned = |req_addr[2:0];
    endcase
  end

  always_comb begin
    shifted = mem_rdata >> {addr_q[2:0], 3'b000};
    unique case (size_q)
      2'd0: load_data_d = uns_q ? XLEN'(shifted[7:0])
                                : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      2'd1: load_data_d = uns_q ? XLEN'(shifted[15:0])
                                : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      2'd2: load_data_d = uns_q ? XLEN'(shifted[31:0])
                                : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      default: load_data_d = shifted;
    endcase
  end

  always_comb begin
    unique case (size_q)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0f;
      default: size_mask = 8'hff;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wen_q   <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (req_valid) begin
          wen_q   <= req_wen;
          uns_q   <= req_unsigned;
          size_q  <= req_size;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          rd_q    <= req_rd;
          err_q   <= misaligned;
          rdata_q <= '0;
          state_q <= misaligned ? S_RESP : S_REQ;
        end
        S_REQ: if (mem_ready) state_q <= wen_q ? S_RESP : S_WAIT_R;
        // rvalid coinciding with the request handshake is ignored by construction
        S_WAIT_R: if (mem_rvalid) begin
          rdata_q <= load_data_d;
          state_q <= S_RESP;
        end
        S_RESP: if (resp_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign mem_valid  = (state_q == S_REQ);
  assign mem_wen    = mem_valid & wen_q;
  assign mem_addr   = mem_valid ? {addr_q[XLEN-1:3], 3'b000} : '0;
  assign mem_wdata  = mem_wen ? (wdata_q << {addr_q[2:0], 3'b000}) : '0;
  assign mem_wmask  = mem_wen ? (size_mask << addr_q[2:0]) : 8'h00;
  assign resp_valid = (state_q == S_RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_data  = (resp_valid && !wen_q && !err_q) ? rdata_q : '0;
  assign resp_rd    = (resp_valid && !wen_q) ? rd_q : '0;

endmodule

// File: tb/tb_ysyx_22050039_lsu.sv
// Self-checking bench for ysyx_22050039_lsu: table-driven zero-wait ops plus
// hand-written stall, backpressure and mid-flight reset sequences.
module tb_ysyx_22050039_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_data;
  logic [4:0]  resp_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_22050039_lsu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_err(resp_err)
  );

  typedef struct {
    logic        wen;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [4:0]  rd;
    logic [63:0] rdata;
    logic        err;
    logic [63:0] exp_data;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_wmask;
    logic [4:0]  exp_rd;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic add(input logic wen, input logic [1:0] size, input logic uns,
                     input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd,
                     input logic [63:0] rdata, input logic err, input logic [63:0] exp_data,
                     input logic [63:0] exp_wdata, input logic [7:0] exp_wmask,
                     input logic [4:0] exp_rd);
    vec_t v;
    v.wen = wen; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata; v.rd = rd;
    v.rdata = rdata; v.err = err; v.exp_data = exp_data; v.exp_wdata = exp_wdata;
    v.exp_wmask = exp_wmask; v.exp_rd = exp_rd;
    vq.push_back(v);
  endtask

  task automatic drive_req(input logic wen, input logic [1:0] size, input logic uns,
                           input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [4:0] rd);
    req_wen = wen; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
  endtask

  // Runs one op against a zero-wait memory, checking cycle-exact latency.
  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    @(negedge clk);
    drive_req(v.wen, v.size, v.uns, v.addr, v.wdata, v.rd);
    req_valid = 1'b1;
    check({t, ".req_ready"}, 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (v.err) begin
      check({t, ".err_resp_valid"}, 64'(resp_valid), 64'd1);
      check({t, ".err_flag"}, 64'(resp_err), 64'd1);
      check({t, ".err_data"}, resp_data, 64'd0);
      check({t, ".err_rd"}, 64'(resp_rd), 64'(v.exp_rd));
      check({t, ".err_no_mem"}, 64'(mem_valid), 64'd0);
    end else begin
      check({t, ".mem_valid"}, 64'(mem_valid), 64'd1);
      check({t, ".mem_addr"}, mem_addr, {v.addr[63:3], 3'b000});
      check({t, ".mem_wen"}, 64'(mem_wen), 64'(v.wen));
      check({t, ".mem_wmask"}, 64'(mem_wmask), 64'(v.exp_wmask));
      check({t, ".mem_wdata"}, mem_wdata, v.exp_wdata);
      @(posedge clk); #1;
      if (!v.wen) begin
        check({t, ".wait_no_resp"}, 64'(resp_valid), 64'd0);
        check({t, ".wait_no_mem"}, 64'(mem_valid), 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = v.rdata;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        mem_rdata  = 64'hDEAD_DEAD_DEAD_DEAD;
      end
      check({t, ".resp_valid"}, 64'(resp_valid), 64'd1);
      check({t, ".resp_err"}, 64'(resp_err), 64'd0);
      check({t, ".resp_data"}, resp_data, v.exp_data);
      check({t, ".resp_rd"}, 64'(resp_rd), 64'(v.exp_rd));
    end
    @(posedge clk); #1;
    check({t, ".back_idle"}, 64'(req_ready), 64'd1);
    check({t, ".resp_drop"}, 64'(resp_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; mem_ready = 1'b1; mem_rvalid = 1'b0;
    mem_rdata = '0; resp_ready = 1'b1;
    drive_req(1'b0, 2'd0, 1'b0, 64'd0, 64'd0, 5'd0);

    //  wen size uns addr                     wdata                    rd  rdata                    err exp_data                 exp_wdata                exp_wmask exp_rd
    add(0, 0, 0, 64'h0000_0000_8000_0003, 64'd0,                   5'd1, 64'h0000_0000_8000_0000, 0, 64'hFFFF_FFFF_FFFF_FF80, 64'd0,                   8'h00, 5'd1);
    add(0, 0, 1, 64'h0000_0000_8000_0003, 64'd0,                   5'd2, 64'h0000_0000_8000_0000, 0, 64'h0000_0000_0000_0080, 64'd0,                   8'h00, 5'd2);
    add(1, 1, 0, 64'h0000_0000_8000_0006, 64'h0000_0000_0000_ABCD, 5'd3, 64'd0,                   0, 64'd0,                   64'hABCD_0000_0000_0000, 8'hC0, 5'd0);
    add(0, 2, 0, 64'h0000_0000_8000_0002, 64'd0,                   5'd4, 64'd0,                   1, 64'd0,                   64'd0,                   8'h00, 5'd4);
    add(0, 1, 0, 64'h0000_0000_1000_0004, 64'd0,                   5'd5, 64'h0000_8123_0000_0000, 0, 64'hFFFF_FFFF_FFFF_8123, 64'd0,                   8'h00, 5'd5);
    add(0, 2, 1, 64'h0000_0000_0000_1004, 64'd0,                   5'd6, 64'hDEAD_BEEF_0000_0000, 0, 64'h0000_0000_DEAD_BEEF, 64'd0,                   8'h00, 5'd6);
    add(0, 2, 0, 64'h0000_0000_0000_1004, 64'd0,                   5'd7, 64'hDEAD_BEEF_0000_0000, 0, 64'hFFFF_FFFF_DEAD_BEEF, 64'd0,                   8'h00, 5'd7);
    add(0, 3, 0, 64'h0000_0000_0000_2008, 64'd0,                   5'd8, 64'h0123_4567_89AB_CDEF, 0, 64'h0123_4567_89AB_CDEF, 64'd0,                   8'h00, 5'd8);
    add(1, 3, 0, 64'h0000_0000_0000_3000, 64'h1122_3344_5566_7788, 5'd9, 64'd0,                   0, 64'd0,                   64'h1122_3344_5566_7788, 8'hFF, 5'd0);
    add(1, 0, 0, 64'h0000_0000_0000_3005, 64'h0000_0000_0000_005A, 5'd10, 64'd0,                  0, 64'd0,                   64'h0000_5A00_0000_0000, 8'h20, 5'd0);
    add(1, 2, 0, 64'h0000_0000_0000_3001, 64'h0000_0000_1234_5678, 5'd11, 64'd0,                  1, 64'd0,                   64'd0,                   8'h00, 5'd0);
    add(0, 1, 0, 64'h0000_0000_0000_3003, 64'd0,                   5'd12, 64'd0,                  1, 64'd0,                   64'd0,                   8'h00, 5'd12);
    add(0, 0, 1, 64'h0000_0000_0000_0007, 64'd0,                   5'd13, 64'hFE00_0000_0000_0000, 0, 64'h0000_0000_0000_00FE, 64'd0,                   8'h00, 5'd13);
    add(1, 2, 0, 64'h0000_0000_0000_4004, 64'h0000_0000_CAFE_F00D, 5'd14, 64'd0,                  0, 64'd0,                   64'hCAFE_F00D_0000_0000, 8'hF0, 5'd0);

    repeat (2) @(posedge clk);
    #1;
    check("rst.req_ready", 64'(req_ready), 64'd1);
    check("rst.mem_valid", 64'(mem_valid), 64'd0);
    check("rst.resp_valid", 64'(resp_valid), 64'd0);
    check("rst.mem_addr", mem_addr, 64'd0);
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < vq.size(); i++) run_vec(vq[i], i);

    // Load with memory stall, then rvalid two cycles after handshake; an rvalid
    // coinciding with the handshake must be ignored.
    @(negedge clk);
    drive_req(1'b0, 2'd3, 1'b0, 64'h0000_0000_0000_4010, 64'd0, 5'd20);
    req_valid = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("stall.mem_valid", 64'(mem_valid), 64'd1);
      check("stall.mem_addr", mem_addr, 64'h0000_0000_0000_4010);
      check("stall.mem_wen", 64'(mem_wen), 64'd0);
      check("stall.req_ready", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
    end
    check("stall.still_valid", 64'(mem_valid), 64'd1);
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h5555_5555_5555_5555;
    @(posedge clk); #1;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    check("stall.hs_done", 64'(mem_valid), 64'd0);
    check("stall.early_rvalid_ignored", 64'(resp_valid), 64'd0);
    check("stall.req_ready_wait", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    check("stall.no_resp_yet", 64'(resp_valid), 64'd0);
    mem_rvalid = 1'b1; mem_rdata = 64'hA5A5_0F0F_1234_8765;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_ready = 1'b1;
    check("stall.resp_valid", 64'(resp_valid), 64'd1);
    check("stall.resp_data", resp_data, 64'hA5A5_0F0F_1234_8765);
    check("stall.resp_rd", 64'(resp_rd), 64'd20);
    @(posedge clk); #1;

    // Writeback backpressure: response held, competing request not accepted.
    resp_ready = 1'b0;
    @(negedge clk);
    drive_req(1'b0, 2'd0, 1'b1, 64'h0000_0000_0000_0011, 64'd0, 5'd21);
    req_valid = 1'b1;
    @(posedge clk); #1;
    drive_req(1'b1, 2'd3, 1'b0, 64'h0000_0000_0000_5000, 64'h0BAD_F00D_0BAD_F00D, 5'd22);
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 64'h0000_0000_0000_C300;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("bp.resp_valid", 64'(resp_valid), 64'd1);
      check("bp.resp_data", resp_data, 64'h0000_0000_0000_00C3);
      check("bp.resp_rd", 64'(resp_rd), 64'd21);
      check("bp.req_ready", 64'(req_ready), 64'd0);
      check("bp.no_mem", 64'(mem_valid), 64'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp.idle_after", 64'(req_ready), 64'd1);
    check("bp.resp_cleared", 64'(resp_valid), 64'd0);
    check("bp.not_bypassed", 64'(mem_valid), 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("bp.next_mem_valid", 64'(mem_valid), 64'd1);
    check("bp.next_mem_addr", mem_addr, 64'h0000_0000_0000_5000);
    check("bp.next_wmask", 64'(mem_wmask), 64'hFF);
    @(posedge clk); #1;
    check("bp.next_resp", 64'(resp_valid), 64'd1);
    @(posedge clk); #1;

    // Reset while waiting for read data; a stray rvalid afterwards is dropped.
    @(negedge clk);
    drive_req(1'b0, 2'd0, 1'b0, 64'h0000_0000_0000_6000, 64'd0, 5'd23);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rstw.in_wait", 64'(mem_valid), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("rstw.req_ready", 64'(req_ready), 64'd1);
    check("rstw.resp_valid", 64'(resp_valid), 64'd0);
    mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    check("rstw.stray_resp", 64'(resp_valid), 64'd0);
    check("rstw.stray_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    check("rstw.stray_resp2", 64'(resp_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
